agp32_mem_ctrl: RTL and testbench

Unified instruction/data memory controller that sits directly downstream of the agp32 processor core. It consumes the core's `command`, `PC`, `data_addr`, `data_wdata` and `data_wstrb` outputs. It returns `ready`, `inst_rdata`, `data_rdata`, `mem_start_ready` and `error`. Storage is one word-addressed on-chip RAM with a programmable access latency and a sticky error report.

---
 rtl/agp32_mem_ctrl.sv | 223 ++++++++++++++++++++++
 tb/tb_agp32_mem_ctrl.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/agp32_mem_ctrl.sv
// agp32_mem_ctrl: unified instruction/data memory controller for the agp32 core.
// One word-addressed RAM, programmable access latency, sticky error report.
// Optional build macro AGP32_MEM_CTRL_CLEAR_EN: INIT zeroes every RAM word,
// one word per cycle, before mem_start_ready rises.
module agp32_mem_ctrl #(
    parameter int unsigned MEM_WORDS = 1024,
    parameter int unsigned LATENCY   = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  command,
    input  logic [31:0] PC,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    input  logic [3:0]  data_wstrb,
    output logic        ready,
    output logic [31:0] inst_rdata,
    output logic [31:0] data_rdata,
    output logic        mem_start_ready,
    output logic [1:0]  error
);

    localparam int unsigned IDX_W      = $clog2(MEM_WORDS);
    // Full 33-bit limit so the range check never wraps (0xFFFF_FFFC is out of range).
    localparam logic [32:0] ADDR_LIMIT = 33'(4 * MEM_WORDS);
    localparam logic [3:0]  LAT        = 4'(LATENCY);
    localparam logic [31:0] NOP_WORD   = 32'd63;

    localparam logic [2:0] CmdIdle  = 3'd0;
    localparam logic [2:0] CmdFetch = 3'd1;
    localparam logic [2:0] CmdRead  = 3'd2;
    localparam logic [2:0] CmdWrite = 3'd3;
    localparam logic [2:0] CmdIrq   = 3'd4;

    localparam logic [1:0] ErrRange = 2'd1;
    localparam logic [1:0] ErrAlign = 2'd2;
    localparam logic [1:0] ErrCmd   = 2'd3;

    typedef enum logic [1:0] {StInit, StIdle, StBusy, StErr} state_e;

    logic [31:0] mem [MEM_WORDS];

    state_e            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [2:0]        cmd_q, cmd_d;
    logic [IDX_W-1:0]  pc_idx_q, pc_idx_d;
    logic [IDX_W-1:0]  addr_idx_q, addr_idx_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [3:0]        wstrb_q, wstrb_d;
    logic              ready_q, ready_d;
    logic              msr_q, msr_d;
    logic [1:0]        error_q, error_d;
    logic [31:0]       inst_q, inst_d;
    logic [31:0]       data_q, data_d;

    logic              mem_we;
    logic [3:0]        mem_wmask;
    logic [IDX_W-1:0]  mem_widx;
    logic [31:0]       mem_wdata;

    logic              pc_out_of_range;
    logic              addr_out_of_range;

`ifdef AGP32_MEM_CTRL_CLEAR_EN
    localparam logic [IDX_W:0] WORDS_N = (IDX_W + 1)'(MEM_WORDS);
    logic [IDX_W:0] init_idx_q, init_idx_d;
`endif

    assign pc_out_of_range   = {1'b0, PC} >= ADDR_LIMIT;
    assign addr_out_of_range = {1'b0, data_addr} >= ADDR_LIMIT;

    // Next-state, result and RAM write-port decode.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        cmd_d      = cmd_q;
        pc_idx_d   = pc_idx_q;
        addr_idx_d = addr_idx_q;
        wdata_d    = wdata_q;
        wstrb_d    = wstrb_q;
        ready_d    = ready_q;
        msr_d      = msr_q;
        error_d    = error_q;
        inst_d     = inst_q;
        data_d     = data_q;
        mem_we     = 1'b0;
        mem_wmask  = 4'b0000;
        mem_widx   = addr_idx_q;
        mem_wdata  = wdata_q;
`ifdef AGP32_MEM_CTRL_CLEAR_EN
        init_idx_d = init_idx_q;
`endif

        unique case (state_q)
            StInit: begin
                ready_d = 1'b0;
`ifdef AGP32_MEM_CTRL_CLEAR_EN
                if (init_idx_q < WORDS_N) begin
                    mem_we     = 1'b1;
                    mem_wmask  = 4'b1111;
                    mem_widx   = init_idx_q[IDX_W-1:0];
                    mem_wdata  = 32'd0;
                    init_idx_d = init_idx_q + 1'b1;
                end else begin
                    state_d = StIdle;
                    ready_d = 1'b1;
                    msr_d   = 1'b1;
                end
`else
                state_d = StIdle;
                ready_d = 1'b1;
                msr_d   = 1'b1;
`endif
            end

            StIdle: begin
                if (command != CmdIdle) begin
                    cmd_d      = command;
                    pc_idx_d   = PC[IDX_W+1:2];
                    addr_idx_d = data_addr[IDX_W+1:2];
                    wdata_d    = data_wdata;
                    wstrb_d    = data_wstrb;
                    ready_d    = 1'b0;
                    if (command > CmdIrq) begin
                        state_d = StErr;
                        error_d = ErrCmd;
                    end else if (command == CmdFetch && PC[1:0] != 2'b00) begin
                        state_d = StErr;
                        error_d = ErrAlign;
                    end else if ((command == CmdFetch && pc_out_of_range) ||
                                 ((command == CmdRead || command == CmdWrite) &&
                                  addr_out_of_range)) begin
                        state_d = StErr;
                        error_d = ErrRange;
                    end else begin
                        state_d = StBusy;
                        cnt_d   = LAT;
                    end
                end
            end

            StBusy: begin
                cnt_d = cnt_q - 1'b1;
                // Access completes on the edge where the counter reaches zero.
                if (cnt_q <= 4'd1) begin
                    cnt_d   = 4'd0;
                    state_d = StIdle;
                    ready_d = 1'b1;
                    case (cmd_q)
                        CmdFetch: inst_d = mem[pc_idx_q];
                        CmdRead:  data_d = mem[addr_idx_q];
                        CmdWrite: begin
                            mem_we    = 1'b1;
                            mem_wmask = wstrb_q;
                        end
                        default: ;
                    endcase
                end
            end

            StErr: begin
                ready_d = 1'b0;
            end

            default: state_d = StInit;
        endcase
    end

    // Control and result registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StInit;
            cnt_q      <= 4'd0;
            cmd_q      <= CmdIdle;
            pc_idx_q   <= '0;
            addr_idx_q <= '0;
            wdata_q    <= 32'd0;
            wstrb_q    <= 4'd0;
            ready_q    <= 1'b0;
            msr_q      <= 1'b0;
            error_q    <= 2'd0;
            inst_q     <= NOP_WORD;
            data_q     <= 32'd0;
`ifdef AGP32_MEM_CTRL_CLEAR_EN
            init_idx_q <= '0;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            cmd_q      <= cmd_d;
            pc_idx_q   <= pc_idx_d;
            addr_idx_q <= addr_idx_d;
            wdata_q    <= wdata_d;
            wstrb_q    <= wstrb_d;
            ready_q    <= ready_d;
            msr_q      <= msr_d;
            error_q    <= error_d;
            inst_q     <= inst_d;
            data_q     <= data_d;
`ifdef AGP32_MEM_CTRL_CLEAR_EN
            init_idx_q <= init_idx_d;
`endif
        end
    end

    // RAM byte-lane write port; reset blocks any pending commit.
    always_ff @(posedge clk) begin
        if (!rst && mem_we) begin
            for (int i = 0; i < 4; i++) begin
                if (mem_wmask[i]) begin
                    mem[mem_widx][8*i +: 8] <= mem_wdata[8*i +: 8];
                end
            end
        end
    end

    assign ready           = ready_q;
    assign inst_rdata      = inst_q;
    assign data_rdata      = data_q;
    assign mem_start_ready = msr_q;
    assign error           = error_q;

endmodule

// File: tb/tb_agp32_mem_ctrl.sv
// Scoreboard bench for agp32_mem_ctrl: a driver issues commands and pushes the
// expected result; a monitor pops and compares whenever the DUT completes or errors.
module tb_agp32_mem_ctrl;

    localparam int unsigned MW  = 16;
    localparam int unsigned LAT = 2;
`ifdef AGP32_MEM_CTRL_CLEAR_EN
    localparam int INIT_CYC = MW + 1;
`else
    localparam int INIT_CYC = 1;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [2:0]  command = 3'd0;
    logic [31:0] PC = 32'd0;
    logic [31:0] data_addr = 32'd0;
    logic [31:0] data_wdata = 32'd0;
    logic [3:0]  data_wstrb = 4'd0;
    logic        ready;
    logic [31:0] inst_rdata;
    logic [31:0] data_rdata;
    logic        mem_start_ready;
    logic [1:0]  error;

    agp32_mem_ctrl #(.MEM_WORDS(MW), .LATENCY(LAT)) dut (
        .clk             (clk),
        .rst             (rst),
        .command         (command),
        .PC              (PC),
        .data_addr       (data_addr),
        .data_wdata      (data_wdata),
        .data_wstrb      (data_wstrb),
        .ready           (ready),
        .inst_rdata      (inst_rdata),
        .data_rdata      (data_rdata),
        .mem_start_ready (mem_start_ready),
        .error           (error)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          issue;
        logic [31:0] inst;
        logic [31:0] data;
        logic [1:0]  err;
    } exp_t;

    exp_t sb[$];

    // Reference model state
    logic [31:0] mem_m [MW];
    logic [31:0] inst_m = 32'd63;
    logic [31:0] data_m = 32'd0;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: pops on a completion (ready rising after init) or on an error report.
    logic ready_p = 1'b0, msr_p = 1'b0;
    logic [1:0] err_p = 2'd0;
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (ready && !ready_p && msr_p) begin
                if (sb.size() == 0) begin
                    chk("unexpected_completion", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    chk("latency", 32'(cyc - e.issue), LAT);
                    chk("inst_rdata", inst_rdata, e.inst);
                    chk("data_rdata", data_rdata, e.data);
                    chk("no_error", 32'(error), 32'(e.err));
                end
            end
            if (error != 2'd0 && err_p == 2'd0) begin
                if (sb.size() == 0) begin
                    chk("unexpected_error", 32'(error), 32'd0);
                end else begin
                    e = sb.pop_front();
                    chk("err_latency", 32'(cyc - e.issue), 32'd0);
                    chk("err_code", 32'(error), 32'(e.err));
                    chk("err_ready", 32'(ready), 32'd0);
                    chk("err_inst", inst_rdata, e.inst);
                    chk("err_data", data_rdata, e.data);
                end
            end
        end
        ready_p = ready;
        msr_p   = mem_start_ready;
        err_p   = error;
    end

    function automatic logic [1:0] exp_err(input logic [2:0] c, input logic [31:0] pc,
                                           input logic [31:0] addr);
        logic [31:0] lim;
        lim = 32'(4 * MW);
        if (c > 3'd4) return 2'd3;
        if (c == 3'd1 && pc % 4 != 0) return 2'd2;
        if ((c == 3'd1 && pc >= lim) || ((c == 3'd2 || c == 3'd3) && addr >= lim)) return 2'd1;
        return 2'd0;
    endfunction

    // Called at a negedge with the DUT idle.
    task automatic issue(input logic [2:0] c, input logic [31:0] pc, input logic [31:0] addr,
                         input logic [31:0] wd, input logic [3:0] ws, input bit noise);
        exp_t e;
        logic [1:0] er;
        int n;
        er = exp_err(c, pc, addr);
        if (er == 2'd0) begin
            case (c)
                3'd1: inst_m = mem_m[pc >> 2];
                3'd2: data_m = mem_m[addr >> 2];
                3'd3: for (int i = 0; i < 4; i++)
                          if (ws[i]) mem_m[addr >> 2][8*i +: 8] = wd[8*i +: 8];
                default: ;
            endcase
        end
        e.issue = cyc + 1;
        e.inst  = inst_m;
        e.data  = data_m;
        e.err   = er;
        sb.push_back(e);
        command = c; PC = pc; data_addr = addr; data_wdata = wd; data_wstrb = ws;
        @(posedge clk);
        @(negedge clk);
        command = 3'd0;
        if (er != 2'd0) return;
        n = 0;
        while (!ready && n < 50) begin
            if (noise) begin
                // Commands during BUSY must be ignored.
                command    = 3'($urandom_range(1, 7));
                PC         = $urandom;
                data_addr  = $urandom;
                data_wdata = $urandom;
                data_wstrb = 4'($urandom);
            end
            @(negedge clk);
            n++;
        end
        command = 3'd0;
        if (!ready) chk("completion_timeout", 32'(ready), 32'd1);
    endtask

    // Called at a negedge; asserts reset for one edge, checks reset state and init timing.
    task automatic do_reset();
        int n;
        rst = 1'b1;
        command = 3'd0;
        sb.delete();
        @(posedge clk);
        @(negedge clk);
        chk("rst_ready", 32'(ready), 32'd0);
        chk("rst_msr", 32'(mem_start_ready), 32'd0);
        chk("rst_error", 32'(error), 32'd0);
        chk("rst_inst", inst_rdata, 32'd63);
        chk("rst_data", data_rdata, 32'd0);
`ifdef AGP32_MEM_CTRL_CLEAR_EN
        for (int w = 0; w < MW; w++) mem_m[w] = 32'd0;
`endif
        inst_m = 32'd63;
        data_m = 32'd0;
        rst = 1'b0;
        n = 0;
        while (n < 200) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (mem_start_ready) break;
        end
        chk("init_cycles", 32'(n), 32'(INIT_CYC));
        chk("init_ready", 32'(ready), 32'd1);
    endtask

    // Error scenario: check the report, that later commands are ignored, then reset.
    task automatic err_case(input logic [2:0] c, input logic [31:0] pc, input logic [31:0] addr);
        logic [1:0] er;
        er = exp_err(c, pc, addr);
        issue(c, pc, addr, 32'hDEAD_BEEF, 4'hF, 1'b0);
        command = 3'd3; data_addr = 32'd0; data_wdata = 32'hFFFF_FFFF; data_wstrb = 4'hF;
        @(negedge clk);
        command = 3'd1; PC = 32'd0;
        @(negedge clk);
        command = 3'd0;
        @(negedge clk);
        chk("err_sticky", 32'(error), 32'(er));
        chk("err_ready_low", 32'(ready), 32'd0);
        chk("err_inst_hold", inst_rdata, inst_m);
        chk("err_data_hold", data_rdata, data_m);
        do_reset();
    endtask

    initial begin
        logic [31:0] old;
        for (int w = 0; w < MW; w++) mem_m[w] = 32'd0;
        @(negedge clk);
        do_reset();

        // Fill every word so later reads are defined with or without clearing.
        for (int w = 0; w < MW; w++) issue(3'd3, 32'd0, 32'(w * 4), $urandom, 4'hF, 1'b0);

        // Directed: fetch, byte-lane merge, interrupt handshake, empty strobe.
        issue(3'd1, 32'h10, 32'd0, 32'd0, 4'd0, 1'b0);
        issue(3'd3, 32'd0, 32'h20, 32'h1122_3344, 4'hF, 1'b0);
        issue(3'd3, 32'd0, 32'h21, 32'h0000_AB00, 4'b0010, 1'b0);
        issue(3'd2, 32'd0, 32'h20, 32'd0, 4'd0, 1'b0);
        @(negedge clk);
        chk("byte_merge", data_rdata, 32'h1122_AB44);
        issue(3'd4, 32'd0, 32'd0, 32'd0, 4'd0, 1'b0);
        issue(3'd3, 32'd0, 32'h24, 32'hFFFF_FFFF, 4'b0000, 1'b0);
        issue(3'd2, 32'd0, 32'h27, 32'd0, 4'd0, 1'b0);

        // Randomized legal traffic, with idle gaps and ignored commands during BUSY.
        for (int k = 0; k < 80; k++) begin
            if ($urandom_range(0, 9) < 2) begin
                repeat ($urandom_range(1, 3)) @(negedge clk);
            end else begin
                issue(3'($urandom_range(1, 4)), 32'($urandom_range(0, MW - 1) * 4),
                      32'($urandom_range(0, 4 * MW - 1)), $urandom, 4'($urandom),
                      1'($urandom_range(0, 1)));
            end
        end
        @(negedge clk);

        // Error reporting, one reset per case.
        err_case(3'd1, 32'h6, 32'd0);
        err_case(3'd2, 32'd0, 32'(4 * MW));
        err_case(3'd3, 32'd0, 32'(4 * MW));
        err_case(3'd1, 32'hFFFF_FFFC, 32'd0);
        err_case(3'd7, 32'd0, 32'd0);
        err_case(3'd5, 32'h10, 32'h10);

        // Write aborted by reset during BUSY must not reach memory.
        old = mem_m[5];
        command = 3'd3; data_addr = 32'h14; data_wdata = ~old; data_wstrb = 4'hF;
        @(posedge clk);
        @(negedge clk);
        command = 3'd0;
        do_reset();
        issue(3'd2, 32'd0, 32'h14, 32'd0, 4'd0, 1'b0);

        // Full readback through both ports.
        for (int w = 0; w < MW; w++) issue(3'd2, 32'd0, 32'(w * 4), 32'd0, 4'd0, 1'b0);
        for (int w = 0; w < MW; w++) issue(3'd1, 32'(w * 4), 32'd0, 32'd0, 4'd0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout got %0d expected finish", cyc);
        $fatal(1, "timeout");
    end

endmodule
